// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares one SRAM-like memory port between instruction fetch and
//             MEM-stage data access. Each access runs an address phase, then
//             a data phase. Misaligned data requests are rejected without a
//             bus access.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  // data access side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              data_err,
  // external memory port
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_grant;
  logic                w_pick_data;
  logic                w_legal;
  logic [3:0]          w_wstrb;
  logic                w_unused;

  logic                r_last_data;   // 1 = most recent grant went to data
  logic                r_gnt_data;    // grantee of the transaction in flight
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [3:0]          r_wstrb;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                r_inst_done;
  logic                r_data_done;
  logic                r_data_err;

  // Fetch addresses are word aligned, so their low bits carry no information.
  assign w_unused = ^inst_addr[1:0];

  // Size/alignment legality and lane strobes of the pending data request.
  always_comb begin
    w_legal = 1'b0;
    case (data_sel)
      4'b0001: w_legal = 1'b1;
      4'b0011: w_legal = ~data_addr[0];
      4'b1111: w_legal = (data_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
    w_wstrb = data_wr ? (data_sel << data_addr[1:0]) : 4'b0000;
  end

  // Next-state logic and arbitration. Grants are held off while a done pulse
  // is showing so a requester's stale req is never granted twice.
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_pick_data = data_req & ~(r_last_data & inst_req);
    case (r_state)
      S_IDLE: begin
        if ((inst_req | data_req) & ~r_inst_done & ~r_data_done) begin
          w_grant = 1'b1;
          w_next  = (w_pick_data & ~w_legal) ? S_ERR : S_ADDR;
        end
      end
      S_ADDR:  if (bus_addr_ok) w_next = S_RESP;
      S_RESP:  if (bus_data_ok) w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Latch the grantee and its access fields so the bus sees them stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_data <= 1'b0;
      r_gnt_data  <= 1'b0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_wstrb     <= 4'b0000;
      r_wdata     <= '0;
    end else if (w_grant) begin
      r_last_data <= w_pick_data;
      r_gnt_data  <= w_pick_data;
      if (w_next == S_ADDR) begin
        if (w_pick_data) begin
          r_addr  <= {data_addr[ADDR_W-1:2], 2'b00};
          r_wr    <= data_wr;
          r_wstrb <= w_wstrb;
          r_wdata <= data_wdata;
        end else begin
          r_addr  <= {inst_addr[ADDR_W-1:2], 2'b00};
          r_wr    <= 1'b0;
          r_wstrb <= 4'b0000;
          r_wdata <= '0;
        end
      end
    end
  end

  // Completion: capture read data and pulse the grantee's done for one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_data_err   <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_done <= 1'b0;
      r_data_done <= 1'b0;
      r_data_err  <= 1'b0;
      if ((r_state == S_RESP) && bus_data_ok) begin
        if (r_gnt_data) begin
          r_data_done  <= 1'b1;
          r_data_rdata <= bus_rdata;
        end else begin
          r_inst_done  <= 1'b1;
          r_inst_rdata <= bus_rdata;
        end
      end
      if (w_grant && (w_next == S_ERR)) begin
        r_data_done <= 1'b1;
        r_data_err  <= 1'b1;
      end
    end
  end

  assign bus_req    = (r_state == S_ADDR);
  assign bus_wr     = r_wr;
  assign bus_wstrb  = r_wstrb;
  assign bus_addr   = r_addr;
  assign bus_wdata  = r_wdata;
  assign inst_rdata = r_inst_rdata;
  assign inst_done  = r_inst_done;
  assign data_rdata = r_data_rdata;
  assign data_done  = r_data_done;
  assign data_err   = r_data_err;

endmodule
`default_nettype wire
